// File: rtl/_tl_controller.sv
// Two-road traffic-light controller: four Moore states (A green/yellow, B green/yellow)
// with a saturating 4-bit dwell timer gating each advance.
module _tl_controller #(
    parameter int GREEN_MIN  = 4,
    parameter int YELLOW_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;
    localparam logic [4:0] GREEN_CYCLES  = 5'(GREEN_MIN);
    localparam logic [4:0] YELLOW_CYCLES = 5'(YELLOW_LEN);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] timer_reg;
    logic [4:0] elapsed;
    logic       advance;

    // Cycles spent in the current state including this one; widened so that
    // the comparisons stay meaningful for GREEN_MIN = 1.
    assign elapsed = {1'b0, timer_reg} + 5'd1;

    always_comb begin
        advance    = 1'b0;
        state_next = state_reg;
        case (state_reg)
            S0: begin
                advance    = !Ta && (elapsed >= GREEN_CYCLES);
                state_next = advance ? S1 : S0;
            end
            S1: begin
                advance    = (elapsed == YELLOW_CYCLES);
                state_next = advance ? S2 : S1;
            end
            S2: begin
                advance    = !Tb && (elapsed >= GREEN_CYCLES);
                state_next = advance ? S3 : S2;
            end
            S3: begin
                advance    = (elapsed == YELLOW_CYCLES);
                state_next = advance ? S0 : S3;
            end
            default: begin
                advance    = 1'b1;
                state_next = S0;
            end
        endcase
    end

    function automatic logic [1:0] light_a(input state_t s);
        case (s)
            S0:      return LIGHT_GREEN;
            S1:      return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [1:0] light_b(input state_t s);
        case (s)
            S2:      return LIGHT_GREEN;
            S3:      return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

    // Lights are registered from the next state so they always match state_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S0;
            timer_reg <= 4'd0;
            La        <= LIGHT_GREEN;
            Lb        <= LIGHT_RED;
        end else begin
            state_reg <= state_next;
            La        <= light_a(state_next);
            Lb        <= light_b(state_next);
            if (advance) begin
                timer_reg <= 4'd0;
            end else if (timer_reg != 4'hF) begin
                timer_reg <= timer_reg + 4'd1;
            end
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb__tl_controller.sv
// Bench for _tl_controller: phase/dwell model per instance checked every cycle,
// plus directed scenarios with hand-computed state sequences.
module tb__tl_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       ta    = 1'b0;
    logic       tb    = 1'b0;
    logic [1:0] st_a, la_a, lb_a;
    logic [1:0] st_b, la_b, lb_b;

    _tl_controller dut_a (
        .clk   (clk),
        .reset (reset),
        .Ta    (ta),
        .Tb    (tb),
        .La    (la_a),
        .Lb    (lb_a),
        .state (st_a)
    );

    _tl_controller #(.GREEN_MIN(1), .YELLOW_LEN(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .Ta    (ta),
        .Tb    (tb),
        .La    (la_b),
        .Lb    (lb_b),
        .state (st_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: phase 0..3 in road order, cnt = cycles already spent in that phase.
    int m_phase [2];
    int m_cnt   [2];
    bit m_valid = 1'b0;
    bit rand_on = 1'b0;
    int yrun    = 0;

    int idle_st [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
    int idle_la [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2};
    int idle_lb [12] = '{2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit model_exit(input int i, input logic s_a, input logic s_b);
        int gmin;
        int ylen;
        gmin = (i == 0) ? 4 : 1;
        ylen = (i == 0) ? 2 : 3;
        if (m_phase[i] % 2 == 0)
            return !((m_phase[i] == 0) ? s_a : s_b) && (m_cnt[i] + 1 >= gmin);
        return (m_cnt[i] + 1 == ylen);
    endfunction

    function automatic int exp_light(input int phase, input int road);
        if (road == 0) return (phase < 2) ? phase : 2;
        return (phase >= 2) ? phase - 2 : 2;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                if (model_exit(i, ta, tb)) begin
                    m_phase[i] = (m_phase[i] + 1) % 4;
                    m_cnt[i]   = 0;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_state_a", {30'b0, st_a}, m_phase[0]);
            chk("model_la_a",    {30'b0, la_a}, exp_light(m_phase[0], 0));
            chk("model_lb_a",    {30'b0, lb_a}, exp_light(m_phase[0], 1));
            chk("model_state_b", {30'b0, st_b}, m_phase[1]);
            chk("model_la_b",    {30'b0, la_b}, exp_light(m_phase[1], 0));
            chk("model_lb_b",    {30'b0, lb_b}, exp_light(m_phase[1], 1));
            chk("both_nonred_a", {31'b0, (la_a != 2'd2 && lb_a != 2'd2)}, 0);
            chk("both_nonred_b", {31'b0, (la_b != 2'd2 && lb_b != 2'd2)}, 0);
            chk("code11_a", {31'b0, (la_a == 2'd3 || lb_a == 2'd3)}, 0);
            chk("code11_b", {31'b0, (la_b == 2'd3 || lb_b == 2'd3)}, 0);
            if (rand_on) begin
                if (la_b == 2'd1 || lb_b == 2'd1) begin
                    yrun++;
                end else if (yrun != 0) begin
                    chk("yellow_len_b", yrun, 3);
                    yrun = 0;
                end
            end
        end
    end

    task automatic step(input logic r, input logic a, input logic b);
        reset = r;
        ta    = a;
        tb    = b;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_lights_a(input string name, input int s, input int la, input int lb);
        chk({name, "_state"}, {30'b0, st_a}, s);
        chk({name, "_la"},    {30'b0, la_a}, la);
        chk({name, "_lb"},    {30'b0, lb_a}, lb);
    endtask

    initial begin
        // Reset from unknown state, held two cycles.
        step(1'b1, 1'b0, 1'b0);
        chk_lights_a("rst_hold", 0, 0, 2);
        chk("rst_hold_b_lb", {30'b0, lb_b}, 2);
        step(1'b1, 1'b0, 1'b0);
        chk_lights_a("rst_first", 0, 0, 2);

        // Idle rotation, 24 cycles.
        for (int k = 0; k < 24; k++) begin
            chk("idle_state", {30'b0, st_a}, idle_st[k % 12]);
            chk("idle_la",    {30'b0, la_a}, idle_la[k % 12]);
            chk("idle_lb",    {30'b0, lb_a}, idle_lb[k % 12]);
            step(1'b0, 1'b0, 1'b0);
        end

        // Green hold: Ta high 20 cycles, then low.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            chk("hold_state", {30'b0, st_a}, 0);
            step(1'b0, (k < 20) ? 1'b1 : 1'b0, 1'b0);
        end
        chk("hold_exit", {30'b0, st_a}, 1);

        // Cross-road sensor: Tb while A is green changes nothing.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("cross_state", {30'b0, st_a}, 0);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("cross_exit", {30'b0, st_a}, 1);

        // Early sensor drop on road B.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk_lights_a("early_s2", 2, 2, 0);
            step(1'b0, 1'b0, (k < 2) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            chk_lights_a("early_s3", 3, 2, 1);
            step(1'b0, 1'b0, 1'b0);
        end
        chk_lights_a("early_s0", 0, 0, 2);

        // Reset in the second cycle of S1.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
        chk("midy_pre", {30'b0, st_a}, 1);
        step(1'b1, 1'b0, 1'b0);
        chk_lights_a("midy_rst", 0, 0, 2);
        for (int k = 0; k < 4; k++) begin
            chk("midy_s0", {30'b0, st_a}, 0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("midy_exit", {30'b0, st_a}, 1);

        // Random sensors, both instances tracked by the model.
        step(1'b1, 1'b0, 1'b0);
        yrun    = 0;
        rand_on = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/_tl_controller.md
# _tl_controller

Two-road traffic-light controller that sequences a 2-bit state register through four Moore states, with a per-state dwell timer. It sits above the 2-bit state register and next-state logic, deciding when the held state may advance. It drives the light encodings for road A and road B. The inputs are the two traffic sensors.

## Interface

- GREEN_MIN, default 4: minimum cycles a road stays green. Legal range 1..15.
- YELLOW_LEN, default 2: exact cycles a road stays yellow. Legal range 1..15.

- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- Ta  input  1  road A traffic sensor. 1 = traffic present on A.
- Tb  input  1  road B traffic sensor. 1 = traffic present on B.
- La  output  2  road A light. 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 never driven.
- Lb  output  2  road B light, same encoding as La.
- state  output  2  current registered state, for observation.

## Operation

- State register is 2 bits, binary coded:
  - S0 = 2'b00: A green, B red.
  - S1 = 2'b01: A yellow, B red.
  - S2 = 2'b10: A red, B green.
  - S3 = 2'b11: A red, B yellow.
- Outputs are Moore: La, Lb and state are decoded only from the registered state, never from Ta or Tb directly.
- Dwell timer: 4-bit counter.
  - Cleared to 0 on every state change.
  - Otherwise increments once per cycle.
  - Saturates at 15; it never wraps.
- Transitions, evaluated at each rising edge:
  - S0 -> S1 when Ta == 0 and timer >= GREEN_MIN-1. Otherwise stay in S0.
  - S1 -> S2 when timer == YELLOW_LEN-1. Ta and Tb are ignored.
  - S2 -> S3 when Tb == 0 and timer >= GREEN_MIN-1. Otherwise stay in S2.
  - S3 -> S0 when timer == YELLOW_LEN-1. Ta and Tb are ignored.
- Green hold: a green road with continuous traffic holds indefinitely. The timer sits at 15 and the road leaves green as soon as its sensor drops.
- Sensor drop before minimum green: if the sensor drops before GREEN_MIN cycles have elapsed, the light stays green until the minimum is met, then advances on the first edge where the sensor is 0.
- Sensor pulses: a sensor that pulses 1 for one cycle at the exit edge blocks the exit on that edge only.
- Cross-road sensor: the sensor of the road that is red has no effect.
- Reset:
  - Values: state = S0, timer = 0, La = 2'b00, Lb = 2'b10.
  - Reset has priority over every transition and can be asserted in any state, mid-dwell.
  - Reset held for N cycles keeps the reset values for those N cycles.
- Invariant: at no cycle are La and Lb both non-red.

## Timing

- Latency: a transition takes effect on the rising edge where its condition is true. The new La, Lb and state are visible in the cycle following that edge.
- Green dwell: exactly max(GREEN_MIN, cycles until the sensor is 0) cycles.
- Yellow dwell: exactly YELLOW_LEN cycles.
- Idle period: with Ta = Tb = 0 and default parameters, the full sequence is 12 cycles: S0 ×4, S1 ×2, S2 ×4, S3 ×2.
- First cycle after reset: the first cycle after reset deasserts counts as timer = 0 in S0.

## Test plan

- Reset values:
  - Stimulus: assert reset for 2 cycles from an unknown state.
  - Response: state = 0, La = 0, Lb = 2 during reset and in the first cycle after release.
- Idle rotation:
  - Stimulus: defaults, Ta = Tb = 0 for 24 cycles after reset.
  - Response: the state sequence repeats 0,0,0,0,1,1,2,2,2,2,3,3 twice. La/Lb follow the state decode.
- Green hold:
  - Stimulus: Ta = 1 for 20 cycles after reset, then Ta = 0.
  - Response: state stays 0 for all 20 cycles and enters 1 on the next edge.
- Early sensor drop:
  - Stimulus: Ta = 0 from cycle 1 after entering S2 while Tb = 1 for 2 cycles, then Tb = 0.
  - Response: S2 lasts exactly 4 cycles (GREEN_MIN), then S3 for 2 cycles, then S0.
- Mid-yellow reset:
  - Stimulus: assert reset in the second cycle of S1.
  - Response: the next cycle shows state = 0, La = 0, Lb = 2, timer restarting at 0; S0 again lasts 4 cycles with Ta = 0.
- Safety, parameters and saturation:
  - Stimulus: GREEN_MIN = 1, YELLOW_LEN = 3, random Ta/Tb for 1000 cycles.
  - Response:
    - La and Lb are never both ≠ 2.
    - Yellow always lasts exactly 3 cycles.
    - 2'b11 never appears on La or Lb.
    - The timer never exceeds 15.
